// File: rtl/regdump_pkg.sv
// Shared definitions for the register-dump controller.
//   NUM_REGS_DEFAULT : default number of registers dumped per sequence
//   WCNT_W           : width of the saturating regfile write counter
//   state_t          : controller FSM state encoding
package regdump_pkg;

  localparam int NUM_REGS_DEFAULT = 32;
  localparam int WCNT_W           = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_SETTLE = 3'd2,
    S_SEND   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/regdump_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset, clears count
//   clear  : synchronous clear (takes priority over inc)
//   inc    : increment request; ignored once count is all ones
//   count  : current count value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/regdump_ctrl.sv
// Run-then-dump controller: lets the processor run for a requested number
// of cycles, then walks regfile read port A over every register and streams
// each value out on a valid/ready interface.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start after reset
// RUN    | run_en high, counting processor cycles and regfile writes
// SETTLE | test_reg driven onto read port A, data settling for 1 cycle
// SEND   | beat presented on dump_*, held until dump_ready
// DONE   | all registers sent; counters held; start rearms
//
// Ports:
//   clock, reset            : clock and async active-low reset
//   start, num_cycles       : run request and run length (sampled in IDLE/DONE)
//   run_en, cycle_count     : processor run permission and elapsed cycles
//   wr_en, wr_reg           : observed regfile write port
//   write_count             : saturating count of non-r0 writes during RUN
//   test_mode, test_reg     : read port A override and index
//   reg_data                : read port A data
//   dump_valid/ready/reg/data : dump beat stream
//   done                    : dump complete
module regdump_ctrl
  import regdump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int CYCW     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CYCW-1:0]   num_cycles,
  output logic              run_en,
  output logic [CYCW-1:0]   cycle_count,
  input  logic              wr_en,
  input  logic [4:0]        wr_reg,
  output logic [WCNT_W-1:0] write_count,
  output logic              test_mode,
  output logic [4:0]        test_reg,
  input  logic [31:0]       reg_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [4:0]        dump_reg,
  output logic [31:0]       dump_data,
  output logic              done
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t          state;
  state_t          state_nxt;
  logic [CYCW-1:0] cyc_target;
  logic [CYCW-1:0] cyc_inc;
  logic [4:0]      idx;
  logic            accept;
  logic            capture;
  logic            advance;
  logic            wr_hit;

  assign cyc_inc  = cycle_count + CYCW'(1);
  assign test_reg = idx;
  assign wr_hit   = (state == S_RUN) && wr_en && (wr_reg != 5'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    run_en     = 1'b0;
    test_mode  = 1'b0;
    dump_valid = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (num_cycles != '0) ? S_RUN : S_SETTLE;
        end
      end
      S_RUN: begin
        run_en = 1'b1;
        // Leave on the edge where the count lands on the target so run_en
        // is high for exactly the requested number of cycles.
        if (cyc_inc == cyc_target) begin
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        test_mode = 1'b1;
        capture   = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        test_mode  = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            advance   = 1'b1;
            state_nxt = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        test_mode = 1'b1;
        done      = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = (num_cycles != '0) ? S_RUN : S_SETTLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc_target  <= '0;
      cycle_count <= '0;
      idx         <= '0;
      dump_reg    <= '0;
      dump_data   <= '0;
    end else begin
      if (accept) begin
        cyc_target  <= num_cycles;
        cycle_count <= '0;
        idx         <= '0;
      end
      if (state == S_RUN) begin
        cycle_count <= cyc_inc;
      end
      if (capture) begin
        dump_data <= reg_data;
        dump_reg  <= idx;
      end
      if (advance) begin
        idx <= idx + 5'd1;
      end
    end
  end

  sat_counter #(
    .W (WCNT_W)
  ) u_write_cnt (
    .clock (clock),
    .reset (reset),
    .clear (accept),
    .inc   (wr_hit),
    .count (write_count)
  );

endmodule

// File: tb/tb_regdump_ctrl.sv
module tb_regdump_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  num_cycles;
  logic        run_en;
  logic [7:0]  cycle_count;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [15:0] write_count;
  logic        test_mode;
  logic [4:0]  test_reg;
  logic [31:0] reg_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_reg;
  logic [31:0] dump_data;
  logic        done;
  logic [31:0] noise;

  int n_chk;
  int n_fail;
  int rn;
  bit run_seen;

  regdump_ctrl #(.NUM_REGS(32), .CYCW(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .num_cycles  (num_cycles),
    .run_en      (run_en),
    .cycle_count (cycle_count),
    .wr_en       (wr_en),
    .wr_reg      (wr_reg),
    .write_count (write_count),
    .test_mode   (test_mode),
    .test_reg    (test_reg),
    .reg_data    (reg_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_reg    (dump_reg),
    .dump_data   (dump_data),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] regval(input logic [4:0] k);
    return {8'hA5, 3'b000, k, 8'h3C, 3'b000, ~k};
  endfunction

  // Regfile model: read port A shows the test register only in test mode.
  assign reg_data = (test_mode ? regval(test_reg) : 32'hFFFF_FFFF) ^ noise;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; num_cycles = '0; wr_en = 1'b0; wr_reg = '0;
    dump_ready = 1'b1; noise = '0; n_chk = 0; n_fail = 0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_run_en", run_en, 0);
    chk("rst_test_mode", test_mode, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_write_count", write_count, 0);
    chk("rst_dump_data", dump_data, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_run_en", run_en, 0);

    // Run of 5 cycles with writes r5,r0,r5,r0,r5, then a full dump
    num_cycles = 8'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("a_cycle_count_start", cycle_count, 0);
    rn = 0;
    for (int i = 0; i < 20 && run_en; i++) begin
      wr_en  = 1'b1;
      wr_reg = (rn % 2 == 1) ? 5'd0 : 5'd5;
      rn++;
      @(negedge clock);
    end
    wr_en = 1'b1; wr_reg = 5'd5;  // write after RUN, must not count
    chk("a_run_len", rn, 5);
    chk("a_cycle_count", cycle_count, 5);
    chk("a_settle_test_mode", test_mode, 1);
    chk("a_settle_valid", dump_valid, 0);
    @(negedge clock);
    wr_en = 1'b0; wr_reg = '0;
    for (int k = 0; k < 32; k++) begin
      chk("a_beat_valid", dump_valid, 1);
      chk("a_beat_reg", dump_reg, k);
      chk("a_beat_data", dump_data, regval(5'(k)));
      @(negedge clock);
      if (k != 31) begin
        chk("a_gap_valid", dump_valid, 0);
        @(negedge clock);
      end
    end
    chk("a_done", done, 1);
    chk("a_done_valid", dump_valid, 0);
    chk("a_done_run_en", run_en, 0);
    chk("a_write_count", write_count, 3);
    @(negedge clock);
    chk("a_done_hold", done, 1);
    chk("a_hold_cycle_count", cycle_count, 5);
    chk("a_hold_write_count", write_count, 3);

    // Restart from DONE with 2 cycles; start in RUN is ignored
    num_cycles = 8'd2; start = 1'b1;
    @(negedge clock);
    chk("b_cycle_count_clr", cycle_count, 0);
    chk("b_write_count_clr", write_count, 0);
    chk("b_done_clr", done, 0);
    num_cycles = 8'd7; start = 1'b1;
    rn = 0;
    for (int i = 0; i < 20 && run_en; i++) begin
      rn++;
      @(negedge clock);
      start = 1'b0;
    end
    start = 1'b0;
    chk("b_run_len", rn, 2);
    chk("b_cycle_count", cycle_count, 2);
    @(negedge clock);
    for (int k = 0; k < 7; k++) begin
      chk("b_beat_reg", dump_reg, k);
      repeat (2) @(negedge clock);
    end

    // Backpressure on beat 7 for 3 cycles, read port disturbed meanwhile
    dump_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      chk("b_stall_valid", dump_valid, 1);
      chk("b_stall_reg", dump_reg, 7);
      chk("b_stall_data", dump_data, regval(5'd7));
      if (s < 3) begin
        noise = 32'hFFFF_0000 >> s;
        @(negedge clock);
      end
    end
    dump_ready = 1'b1; noise = '0;
    @(negedge clock);
    chk("b_post_hs_valid", dump_valid, 0);
    @(negedge clock);
    chk("b_beat8_reg", dump_reg, 8);
    chk("b_beat8_data", dump_data, regval(5'd8));
    for (int k = 9; k <= 12; k++) begin
      repeat (2) @(negedge clock);
    end
    chk("b_beat12_reg", dump_reg, 12);

    // Asynchronous reset in the middle of the dump
    #2 reset = 1'b0;
    #1;
    chk("r_run_en", run_en, 0);
    chk("r_test_mode", test_mode, 0);
    chk("r_dump_valid", dump_valid, 0);
    chk("r_done", done, 0);
    chk("r_dump_reg", dump_reg, 0);
    chk("r_dump_data", dump_data, 0);
    chk("r_test_reg", test_reg, 0);
    chk("r_cycle_count", cycle_count, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    num_cycles = 8'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    rn = 0;
    for (int i = 0; i < 20 && run_en; i++) begin
      rn++;
      @(negedge clock);
    end
    chk("r_run_len", rn, 3);
    chk("r_settle_test_reg", test_reg, 0);
    @(negedge clock);
    chk("r_beat0_reg", dump_reg, 0);
    chk("r_beat0_data", dump_data, regval(5'd0));

    // Zero-length run: straight to dump
    #2 reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    num_cycles = 8'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("z_run_en", run_en, 0);
    chk("z_test_mode", test_mode, 1);
    chk("z_settle_valid", dump_valid, 0);
    @(negedge clock);
    chk("z_first_valid", dump_valid, 1);
    chk("z_first_reg", dump_reg, 0);
    run_seen = 1'b0;
    for (int i = 0; i < 62; i++) begin
      if (run_en) run_seen = 1'b1;
      @(negedge clock);
    end
    chk("z_run_never", run_seen, 0);
    chk("z_last_reg", dump_reg, 31);
    chk("z_last_data", dump_data, regval(5'd31));
    chk("z_not_done_yet", done, 0);
    @(negedge clock);
    chk("z_done", done, 1);
    chk("z_cycle_count", cycle_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
